// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit; the control unit
// imports the same op and state encodings for MFHI/MFLO stall generation.
package mult_div_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'b00,
    MD_RUN    = 2'b01,
    MD_FINISH = 2'b10
  } md_state_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the datapath control and the mult/div unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  import mult_div_unit_pkg::*;

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Turns the raw unsigned product or quotient/remainder into final HI/LO,
// applying operand signs and the divide-by-zero result.
module mult_div_unit_sign_fix
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e             op,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic               div_zero,
  input  logic [WIDTH-1:0]   rs_orig,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Select and sign-correct the result; sign flags are zero for unsigned ops.
  // The min/-1 overflow needs no special case: |min| = 2^(W-1) as unsigned,
  // and with both signs set the quotient is left un-negated.
  always_comb begin
    prod_neg = -raw;
    quo      = raw[WIDTH-1:0];
    rem      = raw[2*WIDTH-1:WIDTH];
    hi       = rem;
    lo       = quo;
    case (op)
      MD_MULT: begin
        if (sign_a ^ sign_b) begin
          hi = prod_neg[2*WIDTH-1:WIDTH];
          lo = prod_neg[WIDTH-1:0];
        end
      end
      MD_DIV, MD_DIVU: begin
        if (div_zero) begin
          hi = rs_orig;
          lo = '1;
        end else begin
          if (sign_a ^ sign_b) lo = -quo;
          if (sign_a) hi = -rem;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, plus the architectural HI/LO registers.
//
// state     | meaning
// ----------+-------------------------------------------------------
// MD_IDLE   | waiting; accepts start or MTHI/MTLO (start wins)
// MD_RUN    | one multiply/divide iteration per edge, WIDTH edges
// MD_FINISH | sign-fixed result written to HI/LO, done pulsed
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  md_op_e             op_q;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   rs_q;
  logic               sign_a;
  logic               sign_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               start_signed;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_zero;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Magnitudes of the incoming operands, used only on the launch edge.
  always_comb begin
    start_signed = md_is_signed(bus.op);
    rs_abs = (start_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    rt_abs = (start_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
  end

  // One iteration: multiply keeps {partial product, multiplier} and shifts
  // right; divide keeps {remainder, dividend/quotient} and shifts left.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_abs} : '0);
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, b_abs};
    if (md_is_div(op_q)) begin
      if (!div_diff[WIDTH]) acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  assign div_zero = (b_abs == '0);

  mult_div_unit_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op       (op_q),
    .sign_a   (sign_a),
    .sign_b   (sign_b),
    .div_zero (div_zero),
    .rs_orig  (rs_q),
    .raw      (acc),
    .hi       (fix_hi),
    .lo       (fix_lo)
  );

  // Sequencer, iteration counter, accumulator and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      op_q   <= MD_MULT;
      a_abs  <= '0;
      b_abs  <= '0;
      rs_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            rs_q   <= bus.rs_data;
            a_abs  <= rs_abs;
            b_abs  <= rt_abs;
            sign_a <= start_signed & bus.rs_data[WIDTH-1];
            sign_b <= start_signed & bus.rt_data[WIDTH-1];
            acc    <= md_is_div(bus.op) ? {{WIDTH{1'b0}}, rs_abs} : {{WIDTH{1'b0}}, rt_abs};
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= MD_RUN;
          end else begin
            if (bus.mthi) hi_q <= bus.rs_data;
            if (bus.mtlo) lo_q <= bus.rs_data;
          end
        end
        MD_RUN: begin
          acc <= acc_next;
          if (cnt == CNT_W'(WIDTH - 1)) state <= MD_FINISH;
          else                          cnt   <= cnt + 1'b1;
        end
        MD_FINISH: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= MD_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= MD_IDLE;
        end
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
